// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder stages.
package cla_pkg;

    localparam int CLA_DEFAULT_WIDTH   = 16;
    localparam int CLA_DEFAULT_VALENCY = 4;

    function automatic int cla_num_groups(input int width, input int valency);
        return width / valency;
    endfunction

endpackage

// File: rtl/cla_group_sum.sv
// One group's in-group ripple carries and sum bits, seeded by the resolved group carry.
module cla_group_sum
    import cla_pkg::*;
#(
    parameter int VALENCY = CLA_DEFAULT_VALENCY
) (
    input  logic [VALENCY-1:0] p,
    input  logic [VALENCY-1:0] g,
    input  logic               cin,
    output logic [VALENCY-1:0] sum,
    output logic               cout
);

    logic [VALENCY:0] carry;

    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < VALENCY; i++) begin
            carry[i+1] = g[i] | (p[i] & carry[i]);
        end
    end

    assign sum  = p ^ carry[VALENCY-1:0];
    assign cout = carry[VALENCY];

endmodule

// File: rtl/cla_sum_stage.sv
// Two-stage sum post-processing for the carry-lookahead adder: group carry
// resolution (optionally approximate for low groups) then per-group ripple sums.
module cla_sum_stage
    import cla_pkg::*;
#(
    parameter int  WIDTH         = CLA_DEFAULT_WIDTH,
    parameter int  VALENCY       = CLA_DEFAULT_VALENCY,
    parameter int  APPROX_GROUPS = 0,
    localparam int NG            = cla_num_groups(WIDTH, VALENCY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_g,
    input  logic [NG-1:0]    in_gg,
    input  logic [NG-1:0]    in_gp,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    if (WIDTH % VALENCY != 0) begin : g_bad_width
        $error("cla_sum_stage: WIDTH must be a multiple of VALENCY");
    end
    if (APPROX_GROUPS < 0 || APPROX_GROUPS >= NG) begin : g_bad_approx
        $error("cla_sum_stage: APPROX_GROUPS must lie in 0..NG-1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    c_grp;
        logic             cout;
    } s1_payload_t;

    logic             v1;
    logic             v2;
    logic             adv1;
    logic             adv2;
    logic [NG:0]      c_grp;
    s1_payload_t      s1_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [NG-1:0]    group_cout_unused;

    assign adv2     = !v2 | out_ready;
    assign adv1     = !v1 | adv2;
    assign in_ready = adv1;

    // Low boundaries in approximate mode take only the group generate, dropping the incoming carry.
    always_comb begin
        c_grp    = '0;
        c_grp[0] = in_cin;
        for (int k = 1; k <= NG; k++) begin
            if (k <= APPROX_GROUPS) begin
                c_grp[k] = in_gg[k-1];
            end else begin
                c_grp[k] = in_gg[k-1] | (in_gp[k-1] & c_grp[k-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_q <= '{p: in_p, g: in_g, c_grp: c_grp[NG-1:0], cout: c_grp[NG]};
            end
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_group
        cla_group_sum #(
            .VALENCY(VALENCY)
        ) u_group_sum (
            .p    (s1_q.p[k*VALENCY +: VALENCY]),
            .g    (s1_q.g[k*VALENCY +: VALENCY]),
            .cin  (s1_q.c_grp[k]),
            .sum  (sum_d[k*VALENCY +: VALENCY]),
            .cout (group_cout_unused[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                sum_q  <= sum_d;
                cout_q <= s1_q.cout;
            end
        end
    end

    assign out_valid = v2;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_cla_sum_stage.sv
// Bench for cla_sum_stage: exact (A=0) and approximate (A=1, A=2) instances share
// one input stream and are each compared against an arithmetic reference model.
module tb_cla_sum_stage;
    import cla_pkg::*;

    localparam int W  = 16;
    localparam int V  = 4;
    localparam int NG = W / V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_cin = 1'b0;
    logic [W-1:0]  in_p = '0;
    logic [W-1:0]  in_g = '0;
    logic [NG-1:0] in_gg = '0;
    logic [NG-1:0] in_gp = '0;
    logic [2:0]    in_ready_v;
    logic [2:0]    out_valid_v;
    logic [2:0]    out_cout_v;
    logic [W-1:0]  out_sum_v [3];

    int checks = 0;
    int errors = 0;
    logic [32:0] beats [$];
    int rd_idx [3];

    always #5 clk = ~clk;

    for (genvar j = 0; j < 3; j++) begin : g_dut
        cla_sum_stage #(
            .WIDTH(W),
            .VALENCY(V),
            .APPROX_GROUPS(j)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[j]),
            .in_p      (in_p),
            .in_g      (in_g),
            .in_gg     (in_gg),
            .in_gp     (in_gp),
            .in_cin    (in_cin),
            .out_valid (out_valid_v[j]),
            .out_ready (out_ready),
            .out_sum   (out_sum_v[j]),
            .out_cout  (out_cout_v[j])
        );
    end

    // Reference: exact is plain a+b+cin; approximate groups take carry = "group sum overflows alone".
    function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input int approx);
        int carry;
        int ag;
        int bg;
        int t;
        logic [15:0] s;
        if (approx == 0) begin
            return 17'(a) + 17'(b) + 17'(cin);
        end
        carry = int'(cin);
        s = '0;
        for (int k = 0; k < NG; k++) begin
            ag = int'((a >> (4*k)) & 16'hF);
            bg = int'((b >> (4*k)) & 16'hF);
            t  = ag + bg + carry;
            s[k*4 +: 4] = 4'(t & 15);
            carry = (k + 1 <= approx) ? ((ag + bg) >> 4) : (t >> 4);
        end
        return {1'(carry), s};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int ag;
        int bg;
        in_p   = a ^ b;
        in_g   = a & b;
        in_cin = cin;
        for (int k = 0; k < NG; k++) begin
            ag = int'((a >> (4*k)) & 16'hF);
            bg = int'((b >> (4*k)) & 16'hF);
            in_gg[k] = (ag + bg) >= 16;
            in_gp[k] = (ag ^ bg) == 15;
        end
    endtask

    task automatic check_all_outputs(input string tag, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin);
        logic [16:0] exp;
        for (int j = 0; j < 3; j++) begin
            exp = model_add(a, b, cin, j);
            check_output($sformatf("%s_valid%0d", tag, j), 32'(out_valid_v[j]), 32'd1);
            check_output($sformatf("%s_sum%0d", tag, j), 32'(out_sum_v[j]), 32'(exp[15:0]));
            check_output($sformatf("%s_cout%0d", tag, j), 32'(out_cout_v[j]), 32'(exp[16]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin);
        @(negedge clk);
        apply_stimulus(a, b, cin);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check_output({tag, "_in_ready"}, 32'(in_ready_v[0]), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check_output({tag, "_lat1"}, 32'(out_valid_v[0]), 32'd0);
        @(negedge clk);
        #1 check_all_outputs(tag, a, b, cin);
    endtask

    task automatic run_stream(input string tag, input int n, input int valid_pct, input int ready_pct,
                              input int max_cycles, output int cycles);
        int sent;
        int done;
        logic taken;
        logic [15:0] cur_a;
        logic [15:0] cur_b;
        logic cur_cin;
        logic [32:0] beat;
        logic [16:0] exp;
        sent   = 0;
        cycles = 0;
        taken  = 1'b0;
        beats.delete();
        for (int j = 0; j < 3; j++) rd_idx[j] = 0;
        done = 0;
        while (done < n && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (taken || !in_valid) begin
                in_valid = 1'b0;
                if (sent < n && $urandom_range(99) < valid_pct) begin
                    cur_a   = 16'($urandom);
                    cur_b   = 16'($urandom);
                    cur_cin = 1'($urandom);
                    apply_stimulus(cur_a, cur_b, cur_cin);
                    in_valid = 1'b1;
                end
            end
            taken     = 1'b0;
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            for (int j = 0; j < 3; j++) begin
                if (out_valid_v[j] && out_ready) begin
                    if (rd_idx[j] >= beats.size()) begin
                        check_output($sformatf("%s_spurious%0d", tag, j), 32'(out_valid_v[j]), 32'd0);
                    end else begin
                        beat = beats[rd_idx[j]];
                        rd_idx[j]++;
                        exp = model_add(beat[15:0], beat[31:16], beat[32], j);
                        check_output($sformatf("%s_result%0d", tag, j),
                                     32'({out_cout_v[j], out_sum_v[j]}), 32'(exp));
                    end
                end
            end
            if (in_valid && in_ready_v[0]) begin
                beats.push_back({cur_cin, cur_b, cur_a});
                sent++;
                taken = 1'b1;
            end
            done = rd_idx[0];
            for (int j = 1; j < 3; j++) if (rd_idx[j] < done) done = rd_idx[j];
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check_output($sformatf("%s_count%0d", tag, j), 32'(rd_idx[j]), 32'(n));
        end
    endtask

    initial begin
        int cycles;

        // Reset state, then release
        #2;
        for (int j = 0; j < 3; j++) begin
            check_output($sformatf("rst_valid%0d", j), 32'(out_valid_v[j]), 32'd0);
            check_output($sformatf("rst_sum%0d", j), 32'(out_sum_v[j]), 32'd0);
            check_output($sformatf("rst_cout%0d", j), 32'(out_cout_v[j]), 32'd0);
        end
        check_output("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed exact and approximate corner cases
        send_and_check("full_carry", 16'hFFFF, 16'h0001, 1'b0);
        send_and_check("approx_drop", 16'h000F, 16'h0000, 1'b1);
        send_and_check("approx_gen", 16'h000F, 16'h0001, 1'b0);
        send_and_check("mixed", 16'h0FF0, 16'h00F1, 1'b1);

        // Backpressure: two beats buffer, third is held off, order kept on release
        @(negedge clk);
        out_ready = 1'b0;
        apply_stimulus(16'h1234, 16'h0F0F, 1'b1);
        in_valid = 1'b1;
        #1 check_output("bp_ready_a", 32'(in_ready_v[0]), 32'd1);
        @(negedge clk);
        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b1);
        #1 check_output("bp_ready_b", 32'(in_ready_v[0]), 32'd1);
        @(negedge clk);
        apply_stimulus(16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check_output("bp_ready_full", 32'(in_ready_v[0]), 32'd0);
            check_all_outputs("bp_hold_a", 16'h1234, 16'h0F0F, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check_output("bp_ready_drain", 32'(in_ready_v[0]), 32'd1);
        check_all_outputs("bp_out_a", 16'h1234, 16'h0F0F, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check_all_outputs("bp_out_b", 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        #1 check_all_outputs("bp_out_c", 16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        #1 check_output("bp_empty", 32'(out_valid_v[0]), 32'd0);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        apply_stimulus(16'h0101, 16'h0202, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        apply_stimulus(16'h3333, 16'h4444, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check_output("midrst_pre_valid", 32'(out_valid_v[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            check_output($sformatf("midrst_valid%0d", j), 32'(out_valid_v[j]), 32'd0);
            check_output($sformatf("midrst_sum%0d", j), 32'(out_sum_v[j]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_and_check("post_rst", 16'hABCD, 16'h1357, 1'b1);

        // Back-to-back streaming: one result per clock after two-cycle latency
        do_reset();
        run_stream("stream", 100, 100, 100, 1000, cycles);
        check_output("stream_cycles", 32'(cycles), 32'd102);

        // Random valid/ready traffic
        do_reset();
        run_stream("random", 10000, 70, 60, 60000, cycles);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
